// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes RST_IN release, then releases RST_OUT bits one by one
// (bit 0 first), with a software request that restarts the whole sequence.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 4,
    parameter int MIN_ASSERT  = 4,
    parameter int RELEASE_GAP = 8
) (
    input  logic               CLK,
    input  logic               RST_IN,
    input  logic               SW_RST_REQ,
    output logic [NUM_OUT-1:0] RST_OUT,
    output logic               DONE
);

    localparam int CNT_MAX = (MIN_ASSERT > RELEASE_GAP) ? MIN_ASSERT : RELEASE_GAP;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int IW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {S_ASSERT, S_RELEASE, S_DONE} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;
    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [IW-1:0]          idx, idx_nxt;
    logic [NUM_OUT-1:0]     rst_out_nxt;
    logic                   done_nxt;
    logic                   ma_hit, gap_hit, last_idx;

    // Release path only: the chain shifts in a constant 1 once RST_IN is high.
    always_ff @(posedge CLK or negedge RST_IN) begin
        if (!RST_IN) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];
    assign ma_hit   = rst_sync && (cnt == CW'(MIN_ASSERT - 1));
    assign gap_hit  = (cnt == CW'(RELEASE_GAP - 1));
    assign last_idx = (idx == IW'(NUM_OUT - 1));

    always_ff @(posedge CLK or negedge RST_IN) begin
        if (!RST_IN) begin
            state   <= S_ASSERT;
            cnt     <= '0;
            idx     <= '0;
            RST_OUT <= '0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            RST_OUT <= rst_out_nxt;
            DONE    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        if (SW_RST_REQ) begin
            state_nxt = S_ASSERT;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                S_ASSERT: begin
                    if (!rst_sync) begin
                        cnt_nxt = '0;
                    end else if (ma_hit) begin
                        cnt_nxt   = '0;
                        idx_nxt   = IW'(1);
                        state_nxt = (NUM_OUT == 1) ? S_DONE : S_RELEASE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (gap_hit) begin
                        cnt_nxt = '0;
                        if (last_idx) state_nxt = S_DONE;
                        else          idx_nxt   = idx + IW'(1);
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are next-values of their own flops, so SW_RST_REQ never reaches a pin combinationally.
    always_comb begin
        rst_out_nxt = RST_OUT;
        done_nxt    = DONE;
        if (SW_RST_REQ) begin
            rst_out_nxt = '0;
            done_nxt    = 1'b0;
        end else begin
            case (state)
                S_ASSERT: begin
                    if (ma_hit) begin
                        rst_out_nxt[0] = 1'b1;
                        done_nxt       = (NUM_OUT == 1);
                    end
                end
                S_RELEASE: begin
                    if (gap_hit) begin
                        for (int i = 0; i < NUM_OUT; i++)
                            if (idx == IW'(i)) rst_out_nxt[i] = 1'b1;
                        done_nxt = last_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: constant-table sequences, async-drop corner cases and
// randomized traffic checked against a release-time model, on two parameterizations.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_in, sw, rst2, sw2;
    logic [3:0] rst_out;
    logic       done;
    logic [0:0] rst_out2;
    logic       done2;

    int vectors = 0;
    int errors  = 0;
    int hi1 = 0, lreq1 = 0, hi2 = 0, lreq2 = 0;

    typedef struct {
        logic       rst;
        logic       sw;
        int         n;
        logic [3:0] out;
        logic       done;
    } vec_t;
    vec_t tbl[19];

    reset_sequencer dut (
        .CLK(clk), .RST_IN(rst_in), .SW_RST_REQ(sw), .RST_OUT(rst_out), .DONE(done)
    );

    reset_sequencer #(.SYNC_STAGES(3), .NUM_OUT(1), .MIN_ASSERT(1), .RELEASE_GAP(8)) dut2 (
        .CLK(clk), .RST_IN(rst2), .SW_RST_REQ(sw2), .RST_OUT(rst_out2), .DONE(done2)
    );

    always #5 clk = ~clk;

    // Bit i is released once enough edges have passed since the later of the
    // synchronizer finishing and the last sampled software request.
    function automatic logic [16:0] ref_out(int hi, int lreq, int s, int no, int ma, int rg);
        logic [16:0] r;
        int          base;
        r    = '0;
        base = (lreq > s) ? lreq : s;
        for (int i = 0; i < no; i++) r[i] = (hi >= base + ma + i * rg);
        r[16] = (hi >= base + ma + (no - 1) * rg);
        return r;
    endfunction

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp,
                       input logic gd, input logic ed);
        vectors++;
        if (got !== exp || gd !== ed) begin
            errors++;
            $display("FAIL %s @%0t: RST_OUT=%b DONE=%b, expected RST_OUT=%b DONE=%b",
                     name, $time, got, gd, exp, ed);
        end
    endtask

    task automatic step();
        logic [16:0] r;
        @(posedge clk);
        if (!rst_in) begin hi1 = 0; lreq1 = 0; end
        else begin hi1++; if (sw) lreq1 = hi1; end
        if (!rst2) begin hi2 = 0; lreq2 = 0; end
        else begin hi2++; if (sw2) lreq2 = hi2; end
        #1;
        r = ref_out(hi1, lreq1, 2, 4, 4, 8);
        chk("model_dflt", rst_out, r[3:0], done, r[16]);
        r = ref_out(hi2, lreq2, 3, 1, 1, 8);
        chk("model_n1", {3'b000, rst_out2}, {3'b000, r[0]}, done2, r[16]);
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rst_in = tbl[i].rst;
            sw     = tbl[i].sw;
            repeat (tbl[i].n) step();
            chk($sformatf("table[%0d]", i), rst_out, tbl[i].out, done, tbl[i].done);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0,  3, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0,  5, 4'b0000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0,  1, 4'b0001, 1'b0};
        tbl[3]  = '{1'b1, 1'b0,  7, 4'b0001, 1'b0};
        tbl[4]  = '{1'b1, 1'b0,  1, 4'b0011, 1'b0};
        tbl[5]  = '{1'b1, 1'b0,  8, 4'b0111, 1'b0};
        tbl[6]  = '{1'b1, 1'b0,  7, 4'b0111, 1'b0};
        tbl[7]  = '{1'b1, 1'b0,  1, 4'b1111, 1'b1};
        tbl[8]  = '{1'b1, 1'b0,  5, 4'b1111, 1'b1};
        tbl[9]  = '{1'b1, 1'b1,  1, 4'b0000, 1'b0};
        tbl[10] = '{1'b1, 1'b0,  3, 4'b0000, 1'b0};
        tbl[11] = '{1'b1, 1'b0,  1, 4'b0001, 1'b0};
        tbl[12] = '{1'b1, 1'b0,  8, 4'b0011, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 16, 4'b1111, 1'b1};
        tbl[14] = '{1'b1, 1'b1,  1, 4'b0000, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 12, 4'b0011, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 10, 4'b0000, 1'b0};
        tbl[17] = '{1'b1, 1'b0,  3, 4'b0000, 1'b0};
        tbl[18] = '{1'b1, 1'b0,  1, 4'b0001, 1'b0};

        rst_in = 1'b0; sw = 1'b0; rst2 = 1'b0; sw2 = 1'b0;
        #2;
        chk("reset_state", rst_out, 4'b0000, done, 1'b0);
        chk("reset_state_n1", {3'b000, rst_out2}, 4'b0000, done2, 1'b0);

        run_table(0, 18);

        // RST_IN dropped between edges mid-release clears outputs before the next edge.
        rst_in = 1'b0;
        repeat (2) step();
        rst_in = 1'b1;
        repeat (18) step();
        chk("pre_drop_e18", rst_out, 4'b0011, done, 1'b0);
        #2 rst_in = 1'b0;
        #1 chk("async_drop", rst_out, 4'b0000, done, 1'b0);
        run_table(0, 7);

        // Single-output variant: software request ignored while RST_IN is low.
        rst2 = 1'b0; sw2 = 1'b1;
        repeat (3) step();
        chk("n1_sw_in_reset", {3'b000, rst_out2}, 4'b0000, done2, 1'b0);
        sw2 = 1'b0; rst2 = 1'b1;
        repeat (3) step();
        chk("n1_edge3", {3'b000, rst_out2}, 4'b0000, done2, 1'b0);
        step();
        chk("n1_edge4", {3'b000, rst_out2}, 4'b0001, done2, 1'b1);

        for (int c = 0; c < 1500; c++) begin
            if (!rst_in) rst_in = ($urandom_range(0, 2) == 0);
            else         rst_in = ($urandom_range(0, 149) != 0);
            sw   = ($urandom_range(0, 59) == 0) || (sw && $urandom_range(0, 2) != 0);
            if (!rst2) rst2 = ($urandom_range(0, 2) == 0);
            else       rst2 = ($urandom_range(0, 99) != 0);
            sw2  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_in = 1'b0;
                #1 chk("rand_async_drop", rst_out, 4'b0000, done, 1'b0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
